// File: rtl/host_read_streamer_pkg.sv
// Shared types and defaults for the host read streamer.
// The FSM encoding is fixed at 2 bits.
package host_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/host_read_streamer_if.sv
// Process-side ap_fifo and host-side Xillybus read channel.
// The master drives stimulus; the slave is the streamer.
interface host_read_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_V_din;
  logic                  in_V_write;
  logic                  in_V_full_n;
  logic                  user_r_rden;
  logic                  user_r_empty;
  logic [DATA_WIDTH-1:0] user_r_data;
  logic                  user_r_eof;
  logic                  user_r_open;
  logic [31:0]           frame_len;
  logic [31:0]           words_sent;

  modport master (
    output in_V_din, in_V_write, user_r_rden,
    output user_r_open, frame_len,
    input  in_V_full_n, user_r_empty, user_r_data,
    input  user_r_eof, words_sent
  );

  modport slave (
    input  in_V_din, in_V_write, user_r_rden,
    input  user_r_open, frame_len,
    output in_V_full_n, user_r_empty, user_r_data,
    output user_r_eof, words_sent
  );
endinterface

// File: rtl/stream_sync_fifo.sv
// Synchronous non-FWFT FIFO with registered dout and flush.
// Callers must gate wr_en/rd_en against full/empty.
module stream_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   count
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) begin
        r_dout   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  assign dout  = r_dout;
  assign count = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/host_read_streamer.sv
// HLS ap_fifo stream to Xillybus read channel, with
// frame-length based end-of-file generation.
module host_read_streamer
  import host_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = 4
) (
  input logic                clk,
  input logic                reset_n,
  host_read_streamer_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH+1)'(DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_acc;
  logic [31:0]           r_sent;
  logic [31:0]           r_len;
  logic [ADDR_WIDTH:0]   w_count;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_open;
  logic                  w_full_n;
  logic                  w_empty;
  logic                  w_eof;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_frame_end;

  assign w_open = bus.user_r_open;

  // Flags come from registered state only
  assign w_full_n = (r_state == ST_STREAM)
                 && (w_count < LP_DEPTH)
                 && ((r_len == '0) || (r_acc < r_len));
  assign w_empty  = (r_state != ST_STREAM)
                 || (w_count == '0);
  assign w_eof    = (r_state == ST_DONE);

  // A close drops any transfer offered in the same cycle
  assign w_wr = bus.in_V_write && w_full_n && w_open;
  assign w_rd = bus.user_r_rden && !w_empty && w_open;

  assign w_frame_end = (r_len != '0) && (r_acc == r_len)
                    && (w_count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_open) w_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (!w_open)          w_next = ST_IDLE;
        else if (w_frame_end) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (!w_open) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc  <= '0;
      r_sent <= '0;
      r_len  <= '0;
    end else if (!w_open) begin
      r_acc  <= '0;
      r_sent <= '0;
    end else if (r_state == ST_IDLE) begin
      r_len  <= bus.frame_len;
      r_acc  <= '0;
      r_sent <= '0;
    end else begin
      if (w_wr) r_acc  <= r_acc + 32'd1;
      if (w_rd) r_sent <= r_sent + 32'd1;
    end
  end

  stream_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (!w_open),
    .wr_en   (w_wr),
    .din     (bus.in_V_din),
    .rd_en   (w_rd),
    .dout    (w_dout),
    .count   (w_count)
  );

  assign bus.in_V_full_n  = w_full_n;
  assign bus.user_r_empty = w_empty;
  assign bus.user_r_eof   = w_eof;
  assign bus.user_r_data  = w_dout;
  assign bus.words_sent   = r_sent;
endmodule

// File: tb/tb_host_read_streamer.sv
// Directed plus random stimulus against a queue-based
// behavioural model of the host read streamer.
module tb_host_read_streamer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  host_read_streamer_if #(.DATA_WIDTH(DW)) bus();

  host_read_streamer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 closed, 1 streaming, 2 frame complete
  int          m_st;
  logic [31:0] q[$];
  logic [31:0] m_acc;
  logic [31:0] m_sent;
  logic [31:0] m_len;
  logic [31:0] m_data;

  function automatic logic m_full_n();
    return (m_st == 1) && (q.size() < DEPTH)
        && ((m_len == 0) || (m_acc < m_len));
  endfunction

  function automatic logic m_empty();
    return (m_st != 1) || (q.size() == 0);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("full_n", 32'(bus.in_V_full_n), 32'(m_full_n()));
    chk("empty", 32'(bus.user_r_empty), 32'(m_empty()));
    chk("eof", 32'(bus.user_r_eof), 32'(m_st == 2));
    chk("data", bus.user_r_data, m_data);
    chk("words_sent", bus.words_sent, m_sent);
  endtask

  task automatic step(input logic rst, input logic op,
                      input logic wr, input logic [31:0] din,
                      input logic rd, input logic [31:0] fl);
    logic f, e, endf;
    reset_n          = rst;
    bus.user_r_open  = op;
    bus.in_V_write   = wr;
    bus.in_V_din     = din;
    bus.user_r_rden  = rd;
    bus.frame_len    = fl;
    f    = m_full_n();
    e    = m_empty();
    endf = (m_len != 0) && (m_acc == m_len) && (q.size() == 0);
    @(posedge clk);
    if (!rst) begin
      m_st = 0; q.delete();
      m_acc = 0; m_sent = 0; m_len = 0; m_data = 0;
    end else if (!op) begin
      m_st = 0; q.delete(); m_acc = 0; m_sent = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_len = fl; m_acc = 0; m_sent = 0;
    end else if (m_st == 1) begin
      if (rd && !e) begin
        m_data = q.pop_front();
        m_sent++;
      end
      if (wr && f) begin
        q.push_back(din);
        m_acc++;
      end
      if (endf) m_st = 2;
    end
    #1;
    check_all();
  endtask

  initial begin
    m_st = 0; m_acc = 0; m_sent = 0; m_len = 0; m_data = 0;
    bus.user_r_open = 0; bus.in_V_write = 0; bus.in_V_din = 0;
    bus.user_r_rden = 0; bus.frame_len = 0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom), 1'($urandom), $urandom,
           1'($urandom), $urandom);
    chk("t1_full_n", 32'(bus.in_V_full_n), 0);
    chk("t1_empty", 32'(bus.user_r_empty), 1);
    chk("t1_data", bus.user_r_data, 0);
    chk("t1_sent", bus.words_sent, 0);

    // 2: three words through, unlimited frame
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h11, 0, 0);
    step(1, 1, 1, 32'h22, 0, 0);
    step(1, 1, 1, 32'h33, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    chk("t2_d0", bus.user_r_data, 32'h11);
    step(1, 1, 0, 0, 1, 0);
    chk("t2_d1", bus.user_r_data, 32'h22);
    step(1, 1, 0, 0, 1, 0);
    chk("t2_d2", bus.user_r_data, 32'h33);
    chk("t2_sent", bus.words_sent, 3);
    chk("t2_eof", 32'(bus.user_r_eof), 0);

    // 3: overfill, then one read
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 1, 32'(i), 0, 0);
      if (i == 15) chk("t3_full15", 32'(bus.in_V_full_n), 1);
    end
    chk("t3_full", 32'(bus.in_V_full_n), 0);
    step(1, 1, 0, 0, 1, 0);
    chk("t3_first", bus.user_r_data, 1);
    chk("t3_rise", 32'(bus.in_V_full_n), 1);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 1, 0);
    chk("t3_last", bus.user_r_data, 16);
    chk("t3_empty", 32'(bus.user_r_empty), 1);

    // 4: frame of 4 words ends in eof
    step(1, 0, 0, 0, 0, 4);
    step(1, 1, 0, 0, 0, 4);
    for (int i = 0; i < 6; i++)
      step(1, 1, 1, 32'h40 + 32'(i), 0, 4);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 4);
    chk("t4_d", bus.user_r_data, 32'h43);
    chk("t4_noeof", 32'(bus.user_r_eof), 0);
    step(1, 1, 0, 0, 1, 4);
    chk("t4_eof", 32'(bus.user_r_eof), 1);
    chk("t4_empty", 32'(bus.user_r_empty), 1);
    step(1, 0, 0, 0, 0, 4);
    chk("t4_close", 32'(bus.user_r_eof), 0);

    // 5: close mid-stream, reopen with frame of 2
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 1, 1, 32'hA0 + 32'(i), 0, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 0, 1, 32'hEE, 0, 2);
    chk("t5_empty", 32'(bus.user_r_empty), 1);
    chk("t5_sent", bus.words_sent, 0);
    step(1, 1, 0, 0, 0, 2);
    step(1, 1, 1, 32'hB1, 0, 2);
    step(1, 1, 1, 32'hB2, 0, 2);
    step(1, 1, 1, 32'hB3, 0, 2);
    step(1, 1, 0, 0, 1, 2);
    chk("t5_d0", bus.user_r_data, 32'hB1);
    step(1, 1, 0, 0, 1, 2);
    chk("t5_d1", bus.user_r_data, 32'hB2);
    step(1, 1, 0, 0, 1, 2);
    chk("t5_eof", 32'(bus.user_r_eof), 1);

    // 6: simultaneous read/write at full and at empty
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      step(1, 1, 1, 32'hC0 + 32'(i), 0, 0);
    step(1, 1, 1, 32'hDD, 1, 0);
    chk("t6_pop", bus.user_r_data, 32'hC0);
    chk("t6_full_n", 32'(bus.in_V_full_n), 1);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 1, 0);
    chk("t6_last", bus.user_r_data, 32'hCF);
    step(1, 1, 1, 32'hD5, 1, 0);
    chk("t6_nopop", bus.words_sent, 16);
    chk("t6_empty", 32'(bus.user_r_empty), 0);
    step(1, 1, 0, 0, 1, 0);
    chk("t6_d", bus.user_r_data, 32'hD5);

    // Random traffic with closes, resets and frame lengths
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] fl;
      fl = ($urandom_range(0, 3) == 0) ? 32'd0
                                       : 32'($urandom_range(1, 24));
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 59) != 0),
           1'($urandom), $urandom,
           ($urandom_range(0, 2) != 0), fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
